// File: rtl/seq_mult.sv
// seq_mult: sequential radix-2 shift-add multiplier with a start/busy/done
// handshake. Signed operands are turned into magnitudes on capture, the
// unsigned product is built one partial product per clock, and the sign is
// applied once at the end. Fixed latency of WIDTH+2 cycles from start.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  // Counter must reach WIDTH-1 as its last compared value.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] p_r;

  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_next_s;

  // Two's-complement negation of an operand-width value.
  function automatic logic [WIDTH-1:0] twos_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // Two's-complement negation of a product-width value.
  function automatic logic [2*WIDTH-1:0] twos_p(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             sm);
    if (sm && x[WIDTH-1]) begin
      return twos_w(x);
    end else begin
      return x;
    end
  endfunction

  // One shift-add step: conditionally add the multiplicand into the upper
  // half (keeping the carry), then shift {carry, acc} right by one.
  always_comb begin
    addend_s = {(WIDTH+1){1'b0}};
    if (mplier_r[0]) begin
      addend_s = {1'b0, mcand_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
    acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      p_r      <= {(2*WIDTH){1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= mag(a, signed_mode);
            mplier_r <= mag(b, signed_mode);
            neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= CALC;
          end
        end
        CALC: begin
          acc_r    <= acc_next_s;
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          if (neg_r) begin
            p_r <= twos_p(acc_r);
          end else begin
            p_r <= acc_r;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier; the clocked, multi-cycle successor to the team's 4x4 combinational array multiplier.
- Supports configurable operand width and a per-operation signed/unsigned mode.
- Uses a start/busy/done handshake so a datapath controller can launch one multiply and collect the held product.
- Trades latency for area: one radix-2 partial product per clock.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; p is valid from this cycle on.
- p  output  2*WIDTH  product; held until the next completion.

Interface decisions:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- All other inputs are synchronous to clk.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, p=0, counter=0, internal regs=0.
- Reset asserted mid-operation aborts the operation immediately. No done is issued and p returns to 0.

State machine (IDLE, CALC, FIN):
- IDLE, start=1 at edge k:
  - Capture operands as magnitudes: |a|, |b| if signed_mode and MSB=1, else raw.
  - Capture neg = signed_mode & (a[MSB]^b[MSB]).
  - Clear accumulator and counter; busy=1; go to CALC.
- CALC, edges k+1..k+WIDTH, one iteration per edge:
  - If multiplier LSB=1, add multiplicand to the upper half of the accumulator (WIDTH+1-bit add keeps the carry).
  - Shift {carry, acc} right by 1; increment counter.
  - After the WIDTH-th iteration (edge k+WIDTH), go to FIN.
- FIN, edge k+WIDTH+1:
  - p <= neg ? two's-complement(acc) : acc.
  - done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles from the start cycle. The latency is fixed and independent of operand values.

Boundary conditions:
- Magnitude of the most negative value (e.g. -128 for WIDTH=8) is 2^(WIDTH-1). This is representable as a WIDTH-bit unsigned value and needs no special case.
- The signed product always fits in 2*WIDTH bits; no overflow flag is provided.
- Zero operand in signed mode: a negative zero cannot occur because the negation of 0 is 0. neg still applies harmlessly.
- start while busy=1 is ignored; in-flight operands are unaffected.
- start asserted in the same cycle done=1 is accepted (state is IDLE). This allows back-to-back operations every WIDTH+2 cycles.
- Changes on a, b or signed_mode after capture have no effect on the in-flight result.
- p holds its last value through IDLE and the next CALC. It updates only at FIN.

Test Plan:
- Reset: assert rst_n=0 mid-CALC -> busy=0, done=0, p=0 immediately; no done pulse after release.
- Unsigned, WIDTH=8: a=255, b=255, signed_mode=0 -> done after 10 cycles, p=65025 (0xFE01); busy high for exactly 9 cycles before done.
- Signed, WIDTH=8:
  - a=-128 (0x80), b=-128 -> p=16384 (0x4000).
  - a=-3 (0xFD), b=7 -> p=-21 (0xFFEB).
  - a=0, b=-5 -> p=0.
- Handshake: pulse start during busy with different operands -> ignored, original product returned. Assert start in the done cycle with a=12, b=11 -> second done exactly 10 cycles later with p=132, first p held until then.
- Parameter sweep, WIDTH=4: compare exhaustively against the 4x4 reference product for all 256 unsigned and all 256 signed pairs. Each result requires done 6 cycles after start.
